line_input_ctrl: RTL and testbench
==================================

LINE_INPUT_CTRL -- requirements
Module: line_input_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the line buffer capacity in characters (power of two, 4..256).
REQ-002 The block SHALL have parameter EOL, default 8'd10, giving the ENTER / line-terminator code.
REQ-003 The block SHALL have parameter BKSP, default 8'd8, giving the backspace code.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ch_valid  input  1  producer has a character on ch_data.
REQ-007 ch_data  input  8  ASCII character from the keyboard/stdin source.
REQ-008 ch_ready  output  1  block accepts ch_data this cycle.
REQ-009 line_valid  output  1  a complete line is held and available to the consumer.
REQ-010 line_len  output  $clog2(DEPTH)+1  number of stored characters in the held line.
REQ-011 overflow  output  1  the held or in-progress line lost characters to a full buffer.
REQ-012 rd_en  input  1  consumer requests the next character of the held line.
REQ-013 rd_valid  output  1  rd_data is valid (one cycle after the accepted rd_en).
REQ-014 rd_data  output  8  character read from the line buffer.
REQ-015 line_ack  input  1  consumer releases the held line.
REQ-016 line_count  output  8  number of lines delivered since reset; wraps 255->0.

Function
REQ-017 The block SHALL implement two states, COLLECT and HOLD.
REQ-018 In COLLECT, ch_ready SHALL be 1; a character transfers when ch_valid && ch_ready.
REQ-019 In COLLECT, an accepted character other than EOL/BKSP SHALL be written at index count, and count SHALL increment, when count < DEPTH.
REQ-020 In COLLECT, an accepted ordinary character with count == DEPTH SHALL be dropped and SHALL set overflow.
REQ-021 In COLLECT, accepted BKSP SHALL decrement count when count > 0; with count == 0 it SHALL be ignored; it is never stored.
REQ-022 In COLLECT, accepted EOL SHALL not be stored, SHALL latch line_len = count, SHALL reset rd_ptr to 0, SHALL increment line_count, and SHALL transition to HOLD.
REQ-023 In HOLD, ch_ready SHALL be 0 and line_valid SHALL be 1; an empty line (line_len 0) SHALL still enter HOLD.
REQ-024 In HOLD, rd_en with rd_ptr < line_len SHALL be accepted: on the next cycle rd_valid = 1 and rd_data = buf[rd_ptr]; rd_ptr increments.
REQ-025 In HOLD, rd_en with rd_ptr == line_len SHALL be ignored (rd_valid 0 on the next cycle).
REQ-026 In HOLD, line_ack SHALL return to COLLECT on the next cycle, clearing count, rd_ptr, and overflow, and driving line_valid 0; unread characters are discarded.
REQ-027 rd_en and line_ack asserted in the same cycle SHALL complete the read (rd_valid next cycle) and also release the line.
REQ-028 rd_en and line_ack asserted in COLLECT SHALL be ignored.
REQ-029 rd_valid SHALL be a single-cycle pulse per accepted read, and rd_data SHALL hold its last value otherwise.
REQ-030 line_len SHALL remain stable for the whole of HOLD.

Reset
REQ-031 Asserting reset SHALL force state to COLLECT immediately, regardless of the clock.
REQ-032 Asserting reset SHALL clear count, rd_ptr, line_len, overflow, rd_valid, rd_data, and line_count to 0.
REQ-033 While reset is asserted and after reset, ch_ready SHALL be 1 and line_valid SHALL be 0.
REQ-034 Buffer contents SHALL not be reset.
REQ-035 Reset during HOLD or mid-read SHALL abandon the line without a further rd_valid pulse.

Structure
REQ-036 The state encoding and the default EOL/BKSP codes SHALL live in a shared package, line_input_pkg, for reuse by other stdin-path blocks.
REQ-037 The line buffer SHALL be a sub-module, line_buf_ram: DEPTH x 8, one write port, one registered read port.
REQ-038 All remaining logic SHALL be in line_input_ctrl.

Verification
REQ-039 Send "Hi\n" (0x48, 0x69, 0x0A) -> line_valid = 1, line_len = 2, line_count = 1; two rd_en -> rd_data 0x48 then 0x69; a third rd_en -> no rd_valid.
REQ-040 Send "ab", BKSP, "c", EOL -> line_len = 2 and reads return 0x61, 0x63; BKSP sent first on an empty line -> count stays 0.
REQ-041 With DEPTH = 16, send 20 characters then EOL -> line_len = 16, overflow = 1, reads return the first 16 characters; line_ack -> overflow = 0.
REQ-042 Send EOL alone -> HOLD with line_len = 0; while in HOLD, ch_valid held high gives ch_ready = 0 and no characters are lost; after line_ack, collection resumes.
REQ-043 Read 1 of 3 characters, then line_ack together with rd_en -> one rd_valid pulse, then COLLECT; a new line "x\n" -> rd_data 0x78.
REQ-044 Assert reset asynchronously mid-HOLD -> line_valid drops before the next clock edge and line_count = 0; 256 lines delivered -> line_count wraps to 0.

Source files
------------

// File: rtl/line_input_pkg.sv
// Shared definitions for the stdin line-input path: FSM encoding and the
// default control-character codes.
package line_input_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } line_state_e;

  localparam logic [7:0] EOL_DEFAULT  = 8'd10;
  localparam logic [7:0] BKSP_DEFAULT = 8'd8;

endpackage

// File: rtl/line_buf_ram.sv
// Line buffer: DEPTH x 8 storage with one write port and one registered
// read port. Only the read register is reset; the array keeps its contents.
module line_buf_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Character storage, written one entry per accepted character.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read data; holds its last value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_input_ctrl.sv
// Line-input controller: collects keyboard characters into a line buffer
// with backspace editing, then holds the finished line for a consumer to
// read character by character until it is acknowledged.
module line_input_ctrl
  import line_input_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [7:0] EOL   = EOL_DEFAULT,
  parameter logic [7:0] BKSP  = BKSP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ch_valid,
  input  logic [7:0]             ch_data,
  output logic                   ch_ready,
  output logic                   line_valid,
  output logic [$clog2(DEPTH):0] line_len,
  output logic                   overflow,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [7:0]             rd_data,
  input  logic                   line_ack,
  output logic [7:0]             line_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  line_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] line_len_q, line_len_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    line_count_q, line_count_d;
  logic          rd_valid_q;
  logic          wr_en;
  logic          rd_accept;

  // State and counter registers; reset abandons any held line at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_COLLECT;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      line_len_q   <= '0;
      overflow_q   <= 1'b0;
      line_count_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      line_len_q   <= line_len_d;
      overflow_q   <= overflow_d;
      line_count_q <= line_count_d;
      rd_valid_q   <= rd_accept;
    end
  end

  // Next-state logic: character editing in COLLECT, reads and release in HOLD.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    line_len_d   = line_len_q;
    overflow_d   = overflow_q;
    line_count_d = line_count_q;
    wr_en        = 1'b0;
    rd_accept    = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (ch_valid) begin
          if (ch_data == EOL) begin
            line_len_d   = count_q;
            rd_ptr_d     = '0;
            line_count_d = line_count_q + 8'd1;
            state_d      = ST_HOLD;
          end else if (ch_data == BKSP) begin
            if (count_q != '0) count_d = count_q - ONE_C;
          end else if (count_q < DEPTH_C) begin
            wr_en   = 1'b1;
            count_d = count_q + ONE_C;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // A read issued alongside the release still completes.
        if (rd_en && (rd_ptr_q < line_len_q)) begin
          rd_accept = 1'b1;
          rd_ptr_d  = rd_ptr_q + ONE_C;
        end
        if (line_ack) begin
          state_d    = ST_COLLECT;
          count_d    = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  line_buf_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (reset),
    .we_i    (wr_en),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (ch_data),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign ch_ready   = (state_q == ST_COLLECT);
  assign line_valid = (state_q == ST_HOLD);
  assign line_len   = line_len_q;
  assign overflow   = overflow_q;
  assign rd_valid   = rd_valid_q;
  assign line_count = line_count_q;

endmodule

// File: tb/tb_line_input_ctrl.sv
// Testbench for line_input_ctrl with a queue-based reference model of the
// line editor.
module tb_line_input_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data = '0;
  logic       ch_ready;
  logic       line_valid;
  logic [4:0] line_len;
  logic       overflow;
  logic       rd_en = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       line_ack = 1'b0;
  logic [7:0] line_count;

  line_input_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .line_valid (line_valid),
    .line_len   (line_len),
    .overflow   (overflow),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .line_ack   (line_ack),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] cur_q[$];
  logic [7:0] held_q[$];
  bit         m_ovf;
  int         m_rd;
  int         m_lines;
  logic [7:0] m_last;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    cur_q.delete();
    held_q.delete();
    m_ovf   = 0;
    m_rd    = 0;
    m_lines = 0;
    m_last  = 8'h00;
  endtask

  task automatic model_release();
    cur_q.delete();
    held_q.delete();
    m_ovf = 0;
    m_rd  = 0;
  endtask

  // Drive one character in COLLECT and advance the model.
  task automatic do_char(input logic [7:0] c);
    ch_valid = 1'b1;
    ch_data  = c;
    n_tests++;
    if (ch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL char_ready got %0b exp 1", ch_ready);
    end
    tick();
    ch_valid = 1'b0;
    if (c == 8'd10) begin
      held_q = cur_q;
      cur_q.delete();
      m_rd = 0;
      m_lines++;
    end else if (c == 8'd8) begin
      if (cur_q.size() > 0) void'(cur_q.pop_back());
    end else if (cur_q.size() < DEPTH) begin
      cur_q.push_back(c);
    end else begin
      m_ovf = 1;
    end
  endtask

  // Terminate the line and check the held-line outputs.
  task automatic do_eol();
    logic [4:0] exp_len;
    logic [7:0] exp_cnt;
    do_char(8'd10);
    exp_len = 5'(held_q.size());
    exp_cnt = 8'(m_lines & 255);
    n_tests++;
    if (line_valid !== 1'b1) begin n_fail++; $display("FAIL eol_valid got %0b exp 1", line_valid); end
    n_tests++;
    if (line_len !== exp_len) begin n_fail++; $display("FAIL eol_len got %0d exp %0d", line_len, exp_len); end
    n_tests++;
    if (overflow !== m_ovf) begin n_fail++; $display("FAIL eol_ovf got %0b exp %0b", overflow, m_ovf); end
    n_tests++;
    if (line_count !== exp_cnt) begin n_fail++; $display("FAIL eol_count got %0d exp %0d", line_count, exp_cnt); end
    n_tests++;
    if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL eol_ready got %0b exp 0", ch_ready); end
  endtask

  // Request one character (optionally releasing the line in the same cycle).
  task automatic do_read(input bit with_ack);
    bit exp_v;
    rd_en    = 1'b1;
    line_ack = with_ack;
    tick();
    rd_en    = 1'b0;
    line_ack = 1'b0;
    exp_v = (m_rd < held_q.size());
    if (exp_v) begin
      m_last = held_q[m_rd];
      m_rd++;
    end
    n_tests++;
    if (rd_valid !== exp_v) begin n_fail++; $display("FAIL read_valid got %0b exp %0b", rd_valid, exp_v); end
    n_tests++;
    if (rd_data !== m_last) begin n_fail++; $display("FAIL read_data got %02h exp %02h", rd_data, m_last); end
    if (with_ack) begin
      model_release();
      n_tests++;
      if (line_valid !== 1'b0) begin n_fail++; $display("FAIL ackrd_valid got %0b exp 0", line_valid); end
    end
    tick();
    n_tests++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL read_pulse got %0b exp 0", rd_valid); end
    n_tests++;
    if (rd_data !== m_last) begin n_fail++; $display("FAIL read_hold got %02h exp %02h", rd_data, m_last); end
  endtask

  task automatic do_ack();
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    model_release();
    n_tests++;
    if (line_valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid got %0b exp 0", line_valid); end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ack_ovf got %0b exp 0", overflow); end
    n_tests++;
    if (ch_ready !== 1'b1) begin n_fail++; $display("FAIL ack_ready got %0b exp 1", ch_ready); end
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    tick();
    n_tests++;
    if (ch_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %0b exp 1", ch_ready); end
    n_tests++;
    if (line_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b exp 0", line_valid); end
    n_tests++;
    if ({line_len, overflow, rd_valid} !== 7'd0) begin
      n_fail++; $display("FAIL rst_ctrl got %0d/%0b/%0b exp 0/0/0", line_len, overflow, rd_valid);
    end
    n_tests++;
    if ({rd_data, line_count} !== 16'd0) begin
      n_fail++; $display("FAIL rst_data got %02h/%0d exp 00/0", rd_data, line_count);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (ch_ready !== 1'b1 || line_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_rst got ready %0b valid %0b exp 1 0", ch_ready, line_valid);
    end
  endtask

  task automatic test_hi();
    do_char(8'h48);
    do_char(8'h69);
    do_eol();
    do_read(0);
    do_read(0);
    do_read(0);
    do_ack();
  endtask

  task automatic test_bksp();
    do_char(8'h61); do_char(8'h62); do_char(8'd8); do_char(8'h63);
    do_eol();
    do_read(0); do_read(0);
    do_ack();
    do_char(8'd8); do_char(8'h71);
    do_eol();
    do_read(0); do_read(0);
    do_ack();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) do_char(8'($urandom_range(32, 126)));
    do_eol();
    for (int i = 0; i < 17; i++) do_read(0);
    do_ack();
  endtask

  task automatic test_empty_line();
    do_eol();
    ch_valid = 1'b1;
    ch_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready got %0b exp 0", ch_ready); end
      tick();
    end
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    model_release();
    n_tests++;
    if (ch_ready !== 1'b1 || line_valid !== 1'b0) begin
      n_fail++; $display("FAIL resume got ready %0b valid %0b exp 1 0", ch_ready, line_valid);
    end
    tick();
    ch_valid = 1'b0;
    cur_q.push_back(8'h5A);
    do_eol();
    do_read(0);
    do_ack();
  endtask

  task automatic test_ack_with_read();
    do_char(8'h31); do_char(8'h32); do_char(8'h33);
    do_eol();
    do_read(0);
    do_read(1);
    do_char(8'h78);
    do_eol();
    do_read(0);
    do_ack();
  endtask

  task automatic test_random();
    for (int ln = 0; ln < 10; ln++) begin
      int n = $urandom_range(0, 22);
      int r;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 5) == 0) do_char(8'd8);
        else do_char(8'($urandom_range(32, 126)));
      end
      do_eol();
      r = $urandom_range(0, held_q.size() + 1);
      for (int i = 0; i < r; i++) do_read(0);
      if ($urandom_range(0, 1) == 1) do_read(1);
      else do_ack();
    end
  endtask

  task automatic test_async_reset();
    do_char(8'h41); do_char(8'h42);
    do_eol();
    rd_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (line_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %0b exp 0", line_valid); end
    n_tests++;
    if (line_count !== 8'd0) begin n_fail++; $display("FAIL async_count got %0d exp 0", line_count); end
    n_tests++;
    if (ch_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready got %0b exp 1", ch_ready); end
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL async_rdv got %0b exp 0", rd_valid); end
    reset = 1'b0;
    tick();
    n_tests++;
    if (rd_valid !== 1'b0 || line_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_after got rdv %0b valid %0b exp 0 0", rd_valid, line_valid);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      do_eol();
      do_ack();
    end
    n_tests++;
    if (line_count !== 8'd0) begin n_fail++; $display("FAIL wrap_count got %0d exp 0", line_count); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hi();
    test_bksp();
    test_overflow();
    test_empty_line();
    test_ack_with_read();
    test_random();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
